// File: rtl/act_port_sequencer_pkg.sv
// rtl/act_port_sequencer_pkg.sv - shared sel_i encodings, port indices and data width for the activation port sequencer
package act_port_sequencer_pkg;

    localparam int DataWidth = 16;

    localparam int PORT1 = 0;
    localparam int PORT2 = 1;

    typedef enum logic [1:0] {
        SEL_IDLE = 2'b00,
        SEL_ZERO = 2'b01,
        SEL_ACT1 = 2'b10,
        SEL_ACT2 = 2'b11
    } sel_i_t;

endpackage

// File: rtl/act_rr_arb.sv
// rtl/act_rr_arb.sv - two-requester round-robin arbiter, eligibility mask in, one-hot grant out
module act_rr_arb
    import act_port_sequencer_pkg::*;
#(
    parameter bit RrInit = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_elig,
    output logic [1:0] o_gnt
);

    // r_rr names the port that wins when both are eligible
    logic r_rr;

    always_comb begin
        o_gnt = 2'b00;
        if (i_elig[PORT1] && (!i_elig[PORT2] || !r_rr)) begin
            o_gnt[PORT1] = 1'b1;
        end else if (i_elig[PORT2]) begin
            o_gnt[PORT2] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr <= RrInit;
        end else if (o_gnt[PORT1]) begin
            r_rr <= 1'b1;
        end else if (o_gnt[PORT2]) begin
            r_rr <= 1'b0;
        end
    end

endmodule

// File: rtl/act_port_sequencer.sv
// rtl/act_port_sequencer.sv - act1/act2 port arbitration, PE drive enables and activation select retiming; ACT_SEQ_STATS_EN adds statistics counters
module act_port_sequencer
    import act_port_sequencer_pkg::*;
#(
`ifdef ACT_SEQ_STATS_EN
    parameter int CntWidth = 16,
`endif
    parameter bit RrInit   = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req1_valid,
    input  logic       i_req1_dst,
    output logic       o_req1_ready,
    input  logic       i_req2_valid,
    input  logic       i_req2_dst,
    output logic       o_req2_ready,
    output logic       o_drv1_en,
    output logic       o_drv2_en,
    output logic [1:0] o_sel_i,
    output logic       o_sel_o1,
    output logic       o_sel_o2,
    input  logic       i_out1_ready,
    input  logic       i_out2_ready,
    output logic       o_busy
`ifdef ACT_SEQ_STATS_EN
    ,
    output logic [CntWidth-1:0] o_stat_xfer1,
    output logic [CntWidth-1:0] o_stat_xfer2,
    output logic [CntWidth-1:0] o_stat_stall
`endif
);

    logic [1:0] r_out_q;
    logic [1:0] r_out_qq;
    logic [1:0] w_elig;
    logic [1:0] w_gnt;
    logic [1:0] w_out_nxt;
    logic       w_dst1_rdy;
    logic       w_dst2_rdy;

    assign w_dst1_rdy = i_req1_dst ? i_out2_ready : i_out1_ready;
    assign w_dst2_rdy = i_req2_dst ? i_out2_ready : i_out1_ready;

    // A source port must be neither output-driven now nor last cycle (collision + turnaround)
    assign w_elig[PORT1] = i_rst_n & i_req1_valid & ~r_out_q[PORT1] & ~r_out_qq[PORT1] & w_dst1_rdy;
    assign w_elig[PORT2] = i_rst_n & i_req2_valid & ~r_out_q[PORT2] & ~r_out_qq[PORT2] & w_dst2_rdy;

    act_rr_arb #(
        .RrInit (RrInit)
    ) u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_elig  (w_elig),
        .o_gnt   (w_gnt)
    );

    assign o_req1_ready = w_gnt[PORT1];
    assign o_req2_ready = w_gnt[PORT2];
    assign o_drv1_en    = w_gnt[PORT1] & i_req1_valid;
    assign o_drv2_en    = w_gnt[PORT2] & i_req2_valid;
    assign o_sel_i      = w_gnt[PORT1] ? SEL_ACT1 : (w_gnt[PORT2] ? SEL_ACT2 : SEL_IDLE);

    always_comb begin
        w_out_nxt = 2'b00;
        if (w_gnt[PORT1]) begin
            w_out_nxt[i_req1_dst] = 1'b1;
        end else if (w_gnt[PORT2]) begin
            w_out_nxt[i_req2_dst] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_q  <= 2'b00;
            r_out_qq <= 2'b00;
        end else begin
            r_out_q  <= w_out_nxt;
            r_out_qq <= r_out_q;
        end
    end

    assign o_sel_o1 = r_out_q[PORT1];
    assign o_sel_o2 = r_out_q[PORT2];
    assign o_busy   = |r_out_q;

`ifdef ACT_SEQ_STATS_EN
    logic [CntWidth-1:0] r_stat_xfer1;
    logic [CntWidth-1:0] r_stat_xfer2;
    logic [CntWidth-1:0] r_stat_stall;
    logic                w_stall;

    assign w_stall = (i_req1_valid | i_req2_valid) & ~(|w_gnt);

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_xfer1 <= '0;
            r_stat_xfer2 <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_gnt[PORT1] && (r_stat_xfer1 != '1)) begin
                r_stat_xfer1 <= r_stat_xfer1 + CntWidth'(1);
            end
            if (w_gnt[PORT2] && (r_stat_xfer2 != '1)) begin
                r_stat_xfer2 <= r_stat_xfer2 + CntWidth'(1);
            end
            if (w_stall && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + CntWidth'(1);
            end
        end
    end

    assign o_stat_xfer1 = r_stat_xfer1;
    assign o_stat_xfer2 = r_stat_xfer2;
    assign o_stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_act_port_sequencer.sv
// tb/tb_act_port_sequencer.sv - self-checking bench for act_port_sequencer against a cycle-history reference model
module tb_act_port_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req1_valid, req1_dst, req2_valid, req2_dst;
    logic       out1_ready, out2_ready;
    logic       req1_ready, req2_ready, drv1_en, drv2_en;
    logic       sel_o1, sel_o2, busy;
    logic [1:0] sel_i;
    logic [8:0] obs;

    assign obs = {req1_ready, req2_ready, drv1_en, drv2_en, sel_i, sel_o1, sel_o2, busy};

`ifdef ACT_SEQ_STATS_EN
    logic [15:0] st_x1, st_x2, st_st;
    logic [1:0]  sat_x1, sat_x2, sat_st;
    logic        s_r1, s_r2, s_d1, s_d2, s_o1, s_o2, s_busy;
    logic [1:0]  s_sel_i;
`endif

    act_port_sequencer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req1_valid (req1_valid),
        .i_req1_dst   (req1_dst),
        .o_req1_ready (req1_ready),
        .i_req2_valid (req2_valid),
        .i_req2_dst   (req2_dst),
        .o_req2_ready (req2_ready),
        .o_drv1_en    (drv1_en),
        .o_drv2_en    (drv2_en),
        .o_sel_i      (sel_i),
        .o_sel_o1     (sel_o1),
        .o_sel_o2     (sel_o2),
        .i_out1_ready (out1_ready),
        .i_out2_ready (out2_ready),
        .o_busy       (busy)
`ifdef ACT_SEQ_STATS_EN
        ,
        .o_stat_xfer1 (st_x1),
        .o_stat_xfer2 (st_x2),
        .o_stat_stall (st_st)
`endif
    );

`ifdef ACT_SEQ_STATS_EN
    act_port_sequencer #(.CntWidth(2)) dut_sat (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req1_valid (req1_valid),
        .i_req1_dst   (req1_dst),
        .o_req1_ready (s_r1),
        .i_req2_valid (req2_valid),
        .i_req2_dst   (req2_dst),
        .o_req2_ready (s_r2),
        .o_drv1_en    (s_d1),
        .o_drv2_en    (s_d2),
        .o_sel_i      (s_sel_i),
        .o_sel_o1     (s_o1),
        .o_sel_o2     (s_o2),
        .i_out1_ready (out1_ready),
        .i_out2_ready (out2_ready),
        .o_busy       (s_busy),
        .o_stat_xfer1 (sat_x1),
        .o_stat_xfer2 (sat_x2),
        .o_stat_stall (sat_st)
    );
`endif

    int checks = 0;
    int errors = 0;

    // Model: out_at[c] = port (0/1) the activation unit drives in cycle c
    int         out_at[int];
    int         m_t;
    int         m_prio;
    int         m_g;
    int         m_dst;
    logic [8:0] exp_vec;

    function automatic int port_at(int c);
        return out_at.exists(c) ? out_at[c] : -1;
    endfunction

    task automatic model_reset();
        out_at.delete();
        m_t    = 0;
        m_prio = 0;
        m_g    = -1;
        m_dst  = 0;
    endtask

    task automatic model_expect();
        bit el1, el2;
        int po, pl;
        po  = port_at(m_t);
        pl  = port_at(m_t - 1);
        el1 = req1_valid && po != 0 && pl != 0 && (req1_dst ? out2_ready : out1_ready);
        el2 = req2_valid && po != 1 && pl != 1 && (req2_dst ? out2_ready : out1_ready);
        m_g = -1;
        if (rst_n === 1'b1) begin
            if (el1 && el2) m_g = m_prio;
            else if (el1)   m_g = 0;
            else if (el2)   m_g = 1;
        end
        m_dst   = (m_g == 0) ? int'(req1_dst) : int'(req2_dst);
        exp_vec = {(m_g == 0), (m_g == 1), (m_g == 0), (m_g == 1),
                   (m_g >= 0), (m_g == 1), (po == 0), (po == 1), (po >= 0)};
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            model_reset();
        end else begin
            if (m_g >= 0) begin
                out_at[m_t + 1] = m_dst;
                m_prio = 1 - m_g;
            end
            m_t++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req1_valid = 1'b0; req1_dst = 1'b0; req2_valid = 1'b0; req2_dst = 1'b0;
        out1_ready = 1'b1; out2_ready = 1'b1;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            model_expect();
            tick();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        req1_valid = 1'b1; req1_dst = 1'b1; req2_valid = 1'b1; req2_dst = 1'b0;
        out1_ready = 1'b1; out2_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            model_expect();
            checks++;
            if (obs !== 9'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d got %b exp %b", c, obs, 9'b0);
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req1_valid = 1'b1; req1_dst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            model_expect();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL single_model cyc %0d got %b exp %b", c, obs, exp_vec);
            end
            checks++;
            if (c == 0 && {req1_ready, drv1_en, sel_i} !== 4'b1110) begin
                errors++;
                $display("FAIL single_grant got %b exp 1110", {req1_ready, drv1_en, sel_i});
            end else if (c == 1 && {sel_o1, sel_o2, busy} !== 3'b011) begin
                errors++;
                $display("FAIL single_output got %b exp 011", {sel_o1, sel_o2, busy});
            end else if (c == 2 && obs !== 9'b0) begin
                errors++;
                $display("FAIL single_idle got %b exp 0", obs);
            end
            tick();
            req1_valid = 1'b0;
        end
    endtask

    task automatic test_pair(input string name, input bit d1, input bit d2,
                             input int low1_cycles, input int exp_g1, input int exp_g2);
        int  g1, g2;
        bit  r1, r2;
        do_reset();
        req1_valid = 1'b1; req1_dst = d1; req2_valid = 1'b1; req2_dst = d2;
        g1 = -1; g2 = -1;
        for (int c = 0; c < 7; c++) begin
            out1_ready = (c >= low1_cycles);
            @(negedge clk);
            model_expect();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL %s_model cyc %0d got %b exp %b", name, c, obs, exp_vec);
            end
            r1 = req1_ready; r2 = req2_ready;
            if (r1 && g1 < 0) g1 = c;
            if (r2 && g2 < 0) g2 = c;
            tick();
            if (r1) req1_valid = 1'b0;
            if (r2) req2_valid = 1'b0;
        end
        checks++;
        if (g1 !== exp_g1 || g2 !== exp_g2) begin
            errors++;
            $display("FAIL %s_grant_cycles got %0d/%0d exp %0d/%0d", name, g1, g2, exp_g1, exp_g2);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] mask;
        do_reset();
        mask = '0;
        req1_valid = 1'b1; req1_dst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            model_expect();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL loopback_model cyc %0d got %b exp %b", c, obs, exp_vec);
            end
            if (req1_ready) mask[c] = 1'b1;
            tick();
            if (c == 6) req1_valid = 1'b0;
        end
        checks++;
        if (mask !== 8'b0100_1001) begin
            errors++;
            $display("FAIL loopback_grants got %b exp 01001001", mask);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req1_valid = 1'b1; req1_dst = 1'b1;
        @(negedge clk);
        model_expect();
        checks++;
        if (obs !== exp_vec) begin
            errors++;
            $display("FAIL areset_grant got %b exp %b", obs, exp_vec);
        end
        tick();
        req1_valid = 1'b0;
        #1;
        checks++;
        if ({sel_o2, busy} !== 2'b11) begin
            errors++;
            $display("FAIL areset_before got %b exp 11", {sel_o2, busy});
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({sel_o1, sel_o2, busy} !== 3'b000) begin
            errors++;
            $display("FAIL areset_drop got %b exp 000", {sel_o1, sel_o2, busy});
        end
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            model_expect();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL areset_model cyc %0d got %b exp %b", c, obs, exp_vec);
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_dst   = 1'($urandom_range(0, 1));
            req2_valid = ($urandom_range(0, 3) != 0);
            req2_dst   = 1'($urandom_range(0, 1));
            out1_ready = ($urandom_range(0, 4) != 0);
            out2_ready = ($urandom_range(0, 4) != 0);
            @(negedge clk);
            model_expect();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random_model cyc %0d got %b exp %b", c, obs, exp_vec);
            end
            tick();
        end
    endtask

`ifdef ACT_SEQ_STATS_EN
    task automatic test_stats();
        do_reset();
        req1_valid = 1'b1; req1_dst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            out2_ready = (c < 5);
            @(negedge clk);
            model_expect();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL stats_model cyc %0d got %b exp %b", c, obs, exp_vec);
            end
            tick();
        end
        req1_valid = 1'b0;
        @(negedge clk);
        model_expect();
        checks++;
        if (st_x1 !== 16'd5 || st_x2 !== 16'd0 || st_st !== 16'd3) begin
            errors++;
            $display("FAIL stats_counts got %0d/%0d/%0d exp 5/0/3", st_x1, st_x2, st_st);
        end
        checks++;
        if (sat_x1 !== 2'd3 || sat_x2 !== 2'd0 || sat_st !== 2'd3) begin
            errors++;
            $display("FAIL stats_saturate got %0d/%0d/%0d exp 3/0/3", sat_x1, sat_x2, sat_st);
        end
        tick();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req1_valid = 1'b0; req1_dst = 1'b0; req2_valid = 1'b0; req2_dst = 1'b0;
        out1_ready = 1'b0; out2_ready = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_pair("turnaround", 1'b1, 1'b0, 0, 0, 3);
        test_loopback();
        test_pair("ready_block", 1'b1, 1'b0, 3, 0, 3);
        test_async_reset();
        test_random();
`ifdef ACT_SEQ_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
